// File: rtl/bus_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } bus_state_e;

    localparam logic       bus_owner_fetch = 1'b0;
    localparam logic       bus_owner_data  = 1'b1;
    localparam logic [3:0] bus_be_all      = 4'b1111;

endpackage

// File: rtl/bus_arbiter_pick.sv
// Winner selection between fetch and data requests.
// Data has priority, but fetch wins after STARVE_LIMIT consecutive data wins.
module bus_arbiter_pick
    import bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       fetch_valid,
    input  logic       data_valid,
    input  logic [3:0] starve_count,
    output logic       winner,
    output logic [3:0] starve_next
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    always_comb begin
        // NOTE: both outputs get a default first so no path through the block can infer a latch.
        winner      = bus_owner_fetch;
        starve_next = starve_count;
        if (fetch_valid && data_valid) begin
            if (starve_count < LIMIT) begin
                winner      = bus_owner_data;
                starve_next = starve_count + 4'd1;
            end else begin
                winner      = bus_owner_fetch;
                starve_next = 4'd0;
            end
        end else if (data_valid) begin
            winner      = bus_owner_data;
            starve_next = 4'd0;
        end else if (fetch_valid) begin
            winner      = bus_owner_fetch;
            starve_next = 4'd0;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one 32-bit memory bus between instruction fetch and data access.
// One transaction at a time: IDLE (arbitrate) -> ISSUE (wait mem_ready) -> RESPOND (ready pulse).
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        fetch_valid,
    input  logic [31:0] fetch_address,
    output logic        fetch_ready,
    output logic [31:0] fetch_read_data,

    input  logic        data_valid,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [3:0]  data_byte_enable,
    input  logic [31:0] data_write_data,
    output logic        data_ready,
    output logic [31:0] data_read_data,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,

    output logic        grant_owner
);

    bus_state_e state;
    bus_state_e state_next;
    logic [3:0] starve_count;
    logic [3:0] starve_next;
    logic       pick_winner;
    logic       any_valid;

    assign any_valid = fetch_valid | data_valid;

    bus_arbiter_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .fetch_valid  (fetch_valid),
        .data_valid   (data_valid),
        .starve_count (starve_count),
        .winner       (pick_winner),
        .starve_next  (starve_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = ISSUE;
            ISSUE:   if (mem_ready) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_valid       <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_byte_enable <= '0;
            mem_write_data  <= '0;
            grant_owner     <= bus_owner_fetch;
            starve_count    <= '0;
            fetch_ready     <= 1'b0;
            data_ready      <= 1'b0;
            fetch_read_data <= '0;
            data_read_data  <= '0;
        end else begin
            fetch_ready <= 1'b0;
            data_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        mem_valid    <= 1'b1;
                        grant_owner  <= pick_winner;
                        starve_count <= starve_next;
                        if (pick_winner == bus_owner_data) begin
                            mem_write       <= data_write;
                            mem_address     <= data_address;
                            mem_byte_enable <= data_byte_enable;
                            mem_write_data  <= data_write_data;
                        end else begin
                            mem_write       <= 1'b0;
                            mem_address     <= fetch_address;
                            mem_byte_enable <= bus_be_all;
                            mem_write_data  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    // Capture goes to the owner's register only; the other port keeps its last value.
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (grant_owner == bus_owner_data) begin
                            data_read_data <= mem_read_data;
                            data_ready     <= 1'b1;
                        end else begin
                            fetch_read_data <= mem_read_data;
                            fetch_ready     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed cases plus randomized traffic
// against a transaction-level reference of the arbitration rules.
module tb_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_address = '0;
    logic        fetch_ready;
    logic [31:0] fetch_read_data;
    logic        data_valid = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_address = '0;
    logic [3:0]  data_byte_enable = '0;
    logic [31:0] data_write_data = '0;
    logic        data_ready;
    logic [31:0] data_read_data;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic        grant_owner;

    bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_valid      (fetch_valid),
        .fetch_address    (fetch_address),
        .fetch_ready      (fetch_ready),
        .fetch_read_data  (fetch_read_data),
        .data_valid       (data_valid),
        .data_write       (data_write),
        .data_address     (data_address),
        .data_byte_enable (data_byte_enable),
        .data_write_data  (data_write_data),
        .data_ready       (data_ready),
        .data_read_data   (data_read_data),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_byte_enable  (mem_byte_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .grant_owner      (grant_owner)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Pending requests as seen by the requesters, plus reference arbitration state.
    logic        f_pend = 1'b0;
    logic [31:0] f_addr = '0;
    logic        d_pend = 1'b0;
    logic        d_wr   = 1'b0;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_be   = '0;
    logic [31:0] d_wd   = '0;
    int          ref_starve = 0;
    logic [31:0] last_f_rd = '0;
    logic [31:0] last_d_rd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_requests();
        fetch_valid      = f_pend;
        fetch_address    = f_addr;
        data_valid       = d_pend;
        data_write       = d_wr;
        data_address     = d_addr;
        data_byte_enable = d_be;
        data_write_data  = d_wd;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_readies"}, 32'({fetch_ready, data_ready}), 32'd0);
    endtask

    task automatic new_fetch(input logic [31:0] addr);
        f_pend = 1'b1;
        f_addr = addr;
    endtask

    task automatic new_data(input logic wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        d_pend = 1'b1;
        d_wr   = wr;
        d_addr = addr;
        d_be   = be;
        d_wd   = wd;
    endtask

    // Called just after a negedge with requests driven and the arbiter idle.
    // Returns the owner the reference rules expected (0 = fetch, 1 = data).
    task automatic run_txn(input int wait_cycles, input logic [31:0] rd, output int owner);
        logic [31:0] ea;
        logic        ew;
        logic [3:0]  eb;
        if (f_pend && d_pend) begin
            if (ref_starve < LIMIT) begin
                owner = 1;
                ref_starve++;
            end else begin
                owner = 0;
                ref_starve = 0;
            end
        end else begin
            owner = d_pend ? 1 : 0;
            ref_starve = 0;
        end
        if (owner == 1) begin
            ea = d_addr; ew = d_wr; eb = d_be;
        end else begin
            ea = f_addr; ew = 1'b0; eb = 4'hF;
        end

        @(posedge clock); #1;
        check("grant_valid", 32'(mem_valid), 32'd1);
        check("grant_owner", 32'(grant_owner), 32'(owner));
        check("grant_address", mem_address, ea);
        check("grant_write", 32'(mem_write), 32'(ew));
        check("grant_be", 32'(mem_byte_enable), 32'(eb));
        if (owner == 1) check("grant_wdata", mem_write_data, d_wd);
        check("grant_readies", 32'({fetch_ready, data_ready}), 32'd0);

        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clock);
            @(posedge clock); #1;
            check("wait_valid", 32'(mem_valid), 32'd1);
            check("wait_address", mem_address, ea);
            check("wait_be", 32'(mem_byte_enable), 32'(eb));
            check("wait_owner", 32'(grant_owner), 32'(owner));
            check("wait_readies", 32'({fetch_ready, data_ready}), 32'd0);
        end

        @(negedge clock);
        mem_ready     = 1'b1;
        mem_read_data = rd;
        @(posedge clock); #1;
        if (owner == 1) last_d_rd = rd;
        else            last_f_rd = rd;
        check("resp_mem_valid", 32'(mem_valid), 32'd0);
        check("resp_fetch_ready", 32'(fetch_ready), 32'(owner == 0));
        check("resp_data_ready", 32'(data_ready), 32'(owner == 1));
        check("resp_fetch_rdata", fetch_read_data, last_f_rd);
        check("resp_data_rdata", data_read_data, last_d_rd);

        @(negedge clock);
        mem_ready     = 1'b0;
        mem_read_data = $urandom;
        if (owner == 1) d_pend = 1'b0;
        else            f_pend = 1'b0;
        drive_requests();
        @(posedge clock); #1;
        check_quiet("after_resp");
        check("hold_fetch_rdata", fetch_read_data, last_f_rd);
        check("hold_data_rdata", data_read_data, last_d_rd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int owner;
        int exp_order [10];
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Reset values.
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_be", 32'(mem_byte_enable), 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_grant_owner", 32'(grant_owner), 32'd0);
        check("rst_readies", 32'({fetch_ready, data_ready}), 32'd0);
        check("rst_fetch_rdata", fetch_read_data, 32'd0);
        check("rst_data_rdata", data_read_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check_quiet("post_rst_idle");

        // Fetch only, zero-wait bus.
        @(negedge clock);
        new_fetch(32'h0000_FFF0);
        drive_requests();
        run_txn(0, 32'hDEAD_BEEF, owner);
        check("fetch_only_owner", 32'(owner), 32'd0);
        check("fetch_only_rdata", fetch_read_data, 32'hDEAD_BEEF);

        // Data write.
        @(negedge clock);
        new_data(1'b1, 32'h0000_0100, 4'b0011, 32'h0000_1234);
        drive_requests();
        run_txn(0, 32'h5555_AAAA, owner);

        // Both ports continuously valid: starvation limit forces a fetch grant.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!f_pend) new_fetch($urandom & 32'hFFFF_FFFC);
            if (!d_pend) new_data(1'b0, $urandom, 4'hF, $urandom);
            drive_requests();
            run_txn(0, $urandom, owner);
            check("starve_order", 32'(owner), 32'(exp_order[i]));
        end
        @(negedge clock);
        f_pend = 1'b0;
        d_pend = 1'b0;
        drive_requests();
        ref_starve = 0;
        @(posedge clock); #1;
        check_quiet("drain_idle");

        // Slow bus: five wait cycles.
        @(negedge clock);
        new_data(1'b0, 32'h0000_2000, 4'hF, 32'h0);
        drive_requests();
        run_txn(5, 32'hCAFE_F00D, owner);

        // mem_ready in IDLE is ignored.
        @(negedge clock);
        mem_ready = 1'b1;
        @(posedge clock); #1;
        check_quiet("stray_ready_1");
        @(negedge clock);
        mem_ready = 1'b0;
        @(posedge clock); #1;
        check_quiet("stray_ready_2");
        @(negedge clock);
        new_fetch(32'h0000_0040);
        drive_requests();
        run_txn(1, 32'h0BAD_F00D, owner);

        // Reset while in ISSUE abandons the transaction.
        @(negedge clock);
        new_fetch(32'h0000_0080);
        drive_requests();
        @(posedge clock); #1;
        check("pre_rst_valid", 32'(mem_valid), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(mem_valid), 32'd0);
        check("async_rst_owner", 32'(grant_owner), 32'd0);
        f_pend = 1'b0;
        drive_requests();
        last_f_rd = '0;
        last_d_rd = '0;
        ref_starve = 0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check_quiet("post_abort");
            @(negedge clock);
        end
        check("post_abort_fetch_rdata", fetch_read_data, 32'd0);
        new_fetch(32'h0000_00C0);
        drive_requests();
        run_txn(0, 32'h1357_9BDF, owner);

        // Randomized traffic against the reference rules.
        for (int n = 0; n < 80; n++) begin
            @(negedge clock);
            if (!f_pend && ($urandom_range(0, 2) != 0)) new_fetch($urandom);
            if (!d_pend && ($urandom_range(0, 2) != 0))
                new_data(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)), $urandom);
            drive_requests();
            if (f_pend || d_pend) begin
                run_txn($urandom_range(0, 4), $urandom, owner);
            end else begin
                @(posedge clock); #1;
                check_quiet("rand_idle");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares the single 32-bit memory bus between the instruction-fetch port and the data (load/store) port. Sits between the fetch unit, the execute-stage memory access logic, and the external bus interface unit. Issues one bus transaction at a time with a registered request/response handshake on every side. Data accesses take priority, with a starvation limit that guarantees fetch progress.

## Interface
- `STARVE_LIMIT`, 4: maximum consecutive data grants while fetch is waiting; range 1..15.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `fetch_valid` in 1: fetch read request; held with `fetch_address` until `fetch_ready`.
- `fetch_address` in 32: fetch byte address; bits [1:0] forwarded unchanged.
- `fetch_ready` out 1: one-cycle pulse; `fetch_read_data` valid in the same cycle.
- `fetch_read_data` out 32: read data for fetch.
- `data_valid` in 1: data request; held with all fields until `data_ready`.
- `data_write` in 1: 1 = write, 0 = read.
- `data_address` in 32: data byte address.
- `data_byte_enable` in 4: byte lanes.
- `data_write_data` in 32: store data.
- `data_ready` out 1: one-cycle completion pulse.
- `data_read_data` out 32: load data, valid with `data_ready`.
- `mem_valid` out 1: bus request, held until `mem_ready`.
- `mem_ready` in 1: bus completion, one cycle.
- `mem_write` out 1.
- `mem_address` out 32.
- `mem_byte_enable` out 4: fetch always drives 4'b1111.
- `mem_write_data` out 32.
- `mem_read_data` in 32: sampled on the `mem_ready` cycle.
- `grant_owner` out 1: 0 = fetch, 1 = data; owner of the current or last transaction.

## Operation
- States: IDLE, ISSUE, RESPOND.
- IDLE, no valid requester: stay in IDLE.
- IDLE, any valid requester: pick a winner, latch its fields into the `mem_*` registers, set `grant_owner`, go to ISSUE.
- Winner selection in IDLE:
  - Only one port valid: that port wins.
  - Both valid and `starve_count` < STARVE_LIMIT: data wins, `starve_count`++.
  - Both valid and `starve_count` == STARVE_LIMIT: fetch wins.
  - `starve_count` clears on any fetch grant, and on a data grant while `fetch_valid`=0.
  - `starve_count` is 4 bits and saturates at STARVE_LIMIT.
- ISSUE: `mem_valid`=1 with fields stable.
  - On `mem_ready`=1: capture `mem_read_data` into the owner's read-data register, drop `mem_valid`, go to RESPOND.
  - Otherwise wait; there is no timeout.
- RESPOND: pulse the owner's ready for one cycle with its read data, then go to IDLE.
- Writes also complete through RESPOND; `data_read_data` then holds the captured bus value, which is don't-care.
- Requesters drop valid one cycle after their ready. IDLE therefore never re-grants a completed request.
- Read-data registers hold their value until the next capture.

## Timing
- Reset values: `mem_valid`, `mem_write`, `fetch_ready`, `data_ready`, `grant_owner` = 0; `mem_address`, `mem_byte_enable`, `mem_write_data`, both read-data outputs = 0; `starve_count`=0; state IDLE.
- Reset mid-transaction drops `mem_valid` asynchronously and abandons the transaction. No ready pulse is issued afterwards.
- Latency, request seen in IDLE at cycle T:
  - `mem_valid` high from T+1.
  - `mem_ready` at cycle R ≥ T+1 gives port ready at R+1.
  - Zero-wait bus (R = T+1): ready at T+2.
  - Minimum 3 cycles per transaction; next grant evaluated at R+2.
- A `mem_ready` received while not in ISSUE is ignored.
- A valid that arrives during ISSUE or RESPOND waits for IDLE.
- A request that drops mid-flight is not detected: the bus transaction completes and the ready pulse still issues.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `bus_pkg`:
  - state enum (IDLE / ISSUE / RESPOND);
  - owner constants `bus_owner_fetch`=0, `bus_owner_data`=1;
  - byte-enable constant `bus_be_all`=4'b1111.
- One sub-module, `bus_arbiter_pick`:
  - inputs: both valids, `starve_count`, STARVE_LIMIT;
  - outputs: winner and next `starve_count`.
- The FSM and capture registers stay in `bus_arbiter`.

## Test plan
- Fetch only, address 0x0000_FFF0, `mem_ready` one cycle after `mem_valid` → `mem_address`=0x0000_FFF0, `mem_byte_enable`=4'hF; `fetch_ready` pulses at T+2 with `mem_read_data` 0xDEADBEEF.
- Data write, address 0x100, BE 4'b0011, data 0x1234 → `mem_write`=1, fields match; `data_ready` pulse; `fetch_ready` stays 0.
- Both valid continuously, STARVE_LIMIT=4 → grant order D,D,D,D,F,D,D,D,D,F; `grant_owner` matches.
- Bus wait of 5 cycles → `mem_valid` and fields stable for all wait cycles; ready exactly one cycle after `mem_ready`.
- Reset asserted while in ISSUE → `mem_valid`=0 immediately; no ready pulse; the next fetch request completes normally.
- `mem_ready` pulsed in IDLE → ignored; no ready outputs; state stays IDLE.
